// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one single-cycle ALU between two
// requesters over valid/ready request and response channels.
module alu_share_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [2:0]       r0_op,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_rsp_res,
  output logic             r0_rsp_zero,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r1_op,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_rsp_res,
  output logic             r1_rsp_zero,

  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,

  output logic             busy,
  output logic             grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             prio;
  logic             any_valid;
  logic             winner;
  logic             take;
  logic             rsp_taken;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;

  // ready is combinational in IDLE; gating with rst_n keeps it low while
  // reset is held even if requesters keep valid asserted.
  always_comb begin
    any_valid = r0_valid | r1_valid;
    winner    = (r0_valid & r1_valid) ? prio : r1_valid;
    take      = rst_n & (state == IDLE) & any_valid;
    rsp_taken = grant ? r1_rsp_ready : r0_rsp_ready;
  end

  assign r0_ready    = take & ~winner;
  assign r1_ready    = take & winner;
  assign r0_rsp_res  = res_q;
  assign r1_rsp_res  = res_q;
  assign r0_rsp_zero = zero_q;
  assign r1_rsp_zero = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prio         <= 1'b0;
      grant        <= 1'b0;
      busy         <= 1'b0;
      alu_srcA     <= '0;
      alu_srcB     <= '0;
      alu_ctrl     <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_srcA <= winner ? r1_a  : r0_a;
            alu_srcB <= winner ? r1_b  : r0_b;
            alu_ctrl <= winner ? r1_op : r0_op;
            grant    <= winner;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          res_q        <= alu_res;
          zero_q       <= alu_zero;
          r0_rsp_valid <= ~grant;
          r1_rsp_valid <= grant;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            busy         <= 1'b0;
            prio         <= ~grant;
            state        <= IDLE;
          end
        end
        default: begin
          r0_rsp_valid <= 1'b0;
          r1_rsp_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, and randomized traffic.
module tb_alu_share_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_zero;
  logic         r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_zero;
  logic [W-1:0] r0_a, r0_b, r0_rsp_res, r1_a, r1_b, r1_rsp_res;
  logic [2:0]   r0_op, r1_op, alu_ctrl;
  logic [W-1:0] alu_srcA, alu_srcB, alu_res;
  logic         alu_zero, busy, grant;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_res(r0_rsp_res), .r0_rsp_zero(r0_rsp_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_res(r1_rsp_res), .r1_rsp_zero(r1_rsp_zero),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res  = alu_fn(alu_srcA, alu_srcB, alu_ctrl);
  assign alu_zero = (alu_res == '0);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an op is in flight from its accept until its response
  // handshake; the response becomes visible two cycles after acceptance.
  logic         m_busy, m_prio, m_grant, m_zero, m_w;
  logic [W-1:0] m_a, m_b, m_res;
  logic [2:0]   m_op;
  int           m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_prio = 0; m_grant = 0; m_a = '0; m_b = '0; m_op = '0;
      m_res = '0; m_zero = 0; m_age = 0;
    end else if (!m_busy) begin
      if (r0_valid || r1_valid) begin
        m_w     = (r0_valid && r1_valid) ? m_prio : r1_valid;
        m_busy  = 1; m_grant = m_w; m_age = 1;
        m_a     = m_w ? r1_a : r0_a;
        m_b     = m_w ? r1_b : r0_b;
        m_op    = m_w ? r1_op : r0_op;
      end
    end else if (m_age == 1) begin
      m_res  = alu_fn(m_a, m_b, m_op);
      m_zero = (m_res == '0);
      m_age  = 2;
    end else if (m_grant ? r1_rsp_ready : r0_rsp_ready) begin
      m_busy = 0;
      m_prio = ~m_grant;
    end
  end

  logic e0r, e1r, e0v, e1v;
  always @(negedge clk) begin
    e0r = rst_n && !m_busy && r0_valid && (!r1_valid || !m_prio);
    e1r = rst_n && !m_busy && r1_valid && (!r0_valid || m_prio);
    e0v = m_busy && m_age >= 2 && !m_grant;
    e1v = m_busy && m_age >= 2 && m_grant;
    chk("r0_ready", r0_ready, e0r);
    chk("r1_ready", r1_ready, e1r);
    chk("busy", busy, m_busy);
    chk("grant", grant, m_grant);
    chk("alu_srcA", alu_srcA, m_a);
    chk("alu_srcB", alu_srcB, m_b);
    chk("alu_ctrl", alu_ctrl, m_op);
    chk("r0_rsp_valid", r0_rsp_valid, e0v);
    chk("r1_rsp_valid", r1_rsp_valid, e1v);
    if (e0v || !rst_n) begin
      chk("r0_rsp_res", r0_rsp_res, m_res);
      chk("r0_rsp_zero", r0_rsp_zero, m_zero);
    end
    if (e1v || !rst_n) begin
      chk("r1_rsp_res", r1_rsp_res, m_res);
      chk("r1_rsp_zero", r1_rsp_zero, m_zero);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns at posedge+1 of the cycle after acceptance.
  task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op);
    bit ok = 0;
    if (n == 0) begin r0_valid = 1; r0_a = a; r0_b = b; r0_op = op; end
    else        begin r1_valid = 1; r1_a = a; r1_b = b; r1_op = op; end
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if ((n == 0) ? r0_ready : r1_ready) ok = 1;
      tick();
    end
    if (n == 0) r0_valid = 0; else r1_valid = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Returns at the negedge of the first cycle with the response valid.
  task automatic wait_rsp(input int n);
    bit ok = 0;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if ((n == 0) ? r0_rsp_valid : r1_rsp_valid) ok = 1;
      else tick();
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  logic [2:0]   ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
  logic [W-1:0] sweep_exp [5] = '{32'hFF, 32'hE1, 32'h0, 32'hFF, 32'h0};
  logic [W-1:0] sampled;
  logic         acc0, acc1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    r0_valid = 1; r0_a = 2; r0_b = 2; r0_op = 3'b000; r0_rsp_ready = 1;
    r1_valid = 1; r1_a = 2; r1_b = 2; r1_op = 3'b000; r1_rsp_ready = 1;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_r0_ready", r0_ready, 0);
    rst_n = 1;

    // Contention from reset: r0 first, then r1, then r0 again.
    @(negedge clk);
    chk("cont_r0_ready", r0_ready, 1);
    chk("cont_r1_ready", r1_ready, 0);
    tick(); r0_valid = 0;
    wait_rsp(0);
    chk("cont_r0_res", r0_rsp_res, 4);
    tick();
    @(negedge clk);
    chk("cont_r1_next", r1_ready, 1);
    tick(); r1_valid = 0;
    wait_rsp(1);
    chk("cont_r1_grant", grant, 1);
    chk("cont_r1_res", r1_rsp_res, 4);
    tick();
    r0_valid = 1; r1_valid = 1;
    @(negedge clk);
    chk("cont2_r0_ready", r0_ready, 1);
    chk("cont2_r1_ready", r1_ready, 0);
    tick(); r0_valid = 0;
    wait_rsp(0); tick();
    @(negedge clk); tick(); r1_valid = 0;
    wait_rsp(1); tick();

    // Single op on r0 with exact latency.
    issue(0, 5, 3, 3'b001);
    @(negedge clk);
    chk("single_srcA", alu_srcA, 5);
    chk("single_srcB", alu_srcB, 3);
    chk("single_ctrl", alu_ctrl, 3'b001);
    chk("single_rsp_early", r0_rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("single_rsp_valid", r0_rsp_valid, 1);
    chk("single_res", r0_rsp_res, 2);
    chk("single_zero", r0_rsp_zero, 0);
    chk("single_r1_valid", r1_rsp_valid, 0);
    tick();

    // Zero flag on r1.
    issue(1, 32'h1234, 32'h1234, 3'b001);
    wait_rsp(1);
    chk("zero_res", r1_rsp_res, 0);
    chk("zero_flag", r1_rsp_zero, 1);
    chk("zero_grant", grant, 1);
    tick();

    // Back-pressure on r0 while r1 waits.
    r0_rsp_ready = 0;
    issue(0, 32'hAAAA, 32'h5555, 3'b000);
    r1_valid = 1; r1_a = 7; r1_b = 9; r1_op = 3'b011;
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); @(negedge clk); end
      chk("bp_valid", r0_rsp_valid, 1);
      chk("bp_res", r0_rsp_res, 32'hFFFF);
      chk("bp_r1_ready", r1_ready, 0);
      chk("bp_busy", busy, 1);
    end
    tick(); r0_rsp_ready = 1;
    @(negedge clk);
    chk("bp_r1_ready_hs", r1_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_r1_accept", r1_ready, 1);
    tick(); r1_valid = 0;
    wait_rsp(1);
    chk("bp_r1_res", r1_rsp_res, 32'hF);
    tick();

    // Op sweep.
    for (int i = 0; i < 5; i++) begin
      issue(0, 32'hF0, 32'h0F, ops[i]);
      @(negedge clk);
      chk("sweep_ctrl", alu_ctrl, ops[i]);
      chk("sweep_alu", alu_res, sweep_exp[i]);
      sampled = alu_res;
      tick();
      @(negedge clk);
      chk("sweep_valid", r0_rsp_valid, 1);
      chk("sweep_res_sampled", r0_rsp_res, sampled);
      chk("sweep_res", r0_rsp_res, sweep_exp[i]);
      tick();
    end

    // Randomized traffic with protocol-respecting requesters.
    r0_valid = 0; r1_valid = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc0 = r0_ready; acc1 = r1_ready;
      tick();
      if (acc0 || !r0_valid) begin
        r0_valid = ($urandom_range(0, 2) != 0);
        r0_a = $urandom; r0_op = 3'($urandom_range(0, 7));
        r0_b = ($urandom_range(0, 3) == 0) ? r0_a : $urandom;
      end
      if (acc1 || !r1_valid) begin
        r1_valid = ($urandom_range(0, 2) != 0);
        r1_a = $urandom; r1_op = 3'($urandom_range(0, 7));
        r1_b = ($urandom_range(0, 3) == 0) ? r1_a : $urandom;
      end
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    r0_valid = 0; r1_valid = 0; r0_rsp_ready = 1; r1_rsp_ready = 1;
    begin
      bit idle = 0;
      for (int t = 0; t < 10 && !idle; t++) begin
        @(negedge clk);
        if (!busy) idle = 1; else tick();
      end
      chk("drain_idle", idle, 1);
      tick();
    end

    // Reset during EXEC drops the op.
    issue(0, 1, 2, 3'b000);
    #2 rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_srcA", alu_srcA, 0);
    chk("rst_srcB", alu_srcB, 0);
    chk("rst_ctrl", alu_ctrl, 0);
    chk("rst_res", r0_rsp_res, 0);
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp0", r0_rsp_valid, 0);
      chk("rst_no_rsp1", r1_rsp_valid, 0);
      tick();
    end
    issue(1, 32'h10, 32'h3, 3'b001);
    wait_rsp(1);
    chk("rst_after_grant", grant, 1);
    chk("rst_after_res", r1_rsp_res, 32'hD);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
